// File: rtl/fir_param_if.sv
// fir_param_if: sample/coefficient bus of the parametrised FIR.
//   master : sample source / coefficient loader (drives VIN, DIN, CLOAD,
//            CADDR, CDATA, CCOMMIT; receives DOUT, VOUT, SAT)
//   slave  : fir_param
// Signals:
//   VIN      sample valid             DIN    signed input sample
//   CLOAD    shadow coefficient write CADDR  tap index of the write
//   CDATA    signed coefficient       CCOMMIT shadow -> active bank copy
//   DOUT     signed filtered output   VOUT   output valid
//   SAT      DOUT of this sample was clipped
interface fir_param_if #(
  parameter int DATA_WIDTH = 13,
  parameter int COEF_WIDTH = 13,
  parameter int TAPS       = 8
);
  localparam int AW = $clog2(TAPS);

  logic                         VIN;
  logic signed [DATA_WIDTH-1:0] DIN;
  logic                         CLOAD;
  logic [AW-1:0]                CADDR;
  logic signed [COEF_WIDTH-1:0] CDATA;
  logic                         CCOMMIT;
  logic signed [DATA_WIDTH-1:0] DOUT;
  logic                         VOUT;
  logic                         SAT;

  modport master (
    output VIN, DIN, CLOAD, CADDR, CDATA, CCOMMIT,
    input  DOUT, VOUT, SAT
  );

  modport slave (
    input  VIN, DIN, CLOAD, CADDR, CDATA, CCOMMIT,
    output DOUT, VOUT, SAT
  );
endinterface

// File: rtl/fir_param.sv
// fir_param: fully pipelined direct-form FIR, one sample per clock, no
// backpressure. Double-buffered coefficient bank (shadow written by CLOAD,
// copied to active by CCOMMIT), round-half-up scaling by SHIFT and
// saturation to DATA_WIDTH with a per-sample SAT flag.
// Ports:
//   CLK    rising-edge clock
//   RST_n  asynchronous active-low reset, clears all state
//   bus    fir_param_if.slave (sample in, coefficient load, result out)
// Latency: $clog2(TAPS)+3 register stages (tap, product, tree, output).
module fir_param #(
  parameter int DATA_WIDTH = 13,
  parameter int COEF_WIDTH = 13,
  parameter int TAPS       = 8,
  parameter int SHIFT      = 12
) (
  input  logic       CLK,
  input  logic       RST_n,
  fir_param_if.slave bus
);
  localparam int AW     = $clog2(TAPS);
  localparam int LVL    = $clog2(TAPS);
  localparam int LEAVES = 1 << LVL;
  localparam int PW     = DATA_WIDTH + COEF_WIDTH;
  localparam int ACC_W  = PW + LVL;
  // one extra bit so adding the rounding constant can never wrap
  localparam int OW     = ACC_W + 1;

  localparam logic [AW:0]   TAPS_C = (AW+1)'(TAPS);
  localparam logic [OW-1:0] ONE    = {{(OW-1){1'b0}}, 1'b1};
  localparam logic [OW-1:0] RND    = (ONE << SHIFT) >> 1;

  logic signed [DATA_WIDTH-1:0] x_q      [TAPS];
  logic signed [COEF_WIDTH-1:0] shadow_q [TAPS];
  logic signed [COEF_WIDTH-1:0] active_q [TAPS];

  logic signed [PW-1:0]         mul_d    [TAPS];
  logic signed [ACC_W-1:0]      prod_d   [LEAVES];
  // heap-ordered adder tree: node i sums nodes 2i and 2i+1, leaves are
  // LEAVES..2*LEAVES-1 (product register), node 1 is the root
  logic signed [ACC_W-1:0]      node_q   [1:2*LEAVES-1];

  logic [LVL+1:0]               vld_q;
  logic signed [OW-1:0]         rnd_sum;
  logic signed [OW-1:0]         scaled;
  logic                         clip_d;
  logic signed [DATA_WIDTH-1:0] dout_d;

  logic signed [DATA_WIDTH-1:0] dout_q;
  logic                         vout_q;
  logic                         sat_q;

  // Delay line and coefficient banks. On a CLOAD+CCOMMIT edge the active
  // bank takes the pre-edge shadow, so the new write waits for the next commit.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      for (int k = 0; k < TAPS; k++) begin
        x_q[k]      <= '0;
        shadow_q[k] <= '0;
        active_q[k] <= '0;
      end
    end else begin
      if (bus.VIN) begin
        x_q[0] <= bus.DIN;
        for (int k = 1; k < TAPS; k++) x_q[k] <= x_q[k-1];
      end
      if (bus.CLOAD && ({1'b0, bus.CADDR} < TAPS_C)) shadow_q[bus.CADDR] <= bus.CDATA;
      if (bus.CCOMMIT) begin
        for (int k = 0; k < TAPS; k++) active_q[k] <= shadow_q[k];
      end
    end
  end

  always_comb begin
    for (int k = 0; k < TAPS; k++) begin
      mul_d[k] = $signed({{COEF_WIDTH{x_q[k][DATA_WIDTH-1]}}, x_q[k]}) *
                 $signed({{DATA_WIDTH{active_q[k][COEF_WIDTH-1]}}, active_q[k]});
    end
  end

  always_comb begin
    for (int k = 0; k < LEAVES; k++) prod_d[k] = '0;
    for (int k = 0; k < TAPS; k++) prod_d[k] = {{LVL{mul_d[k][PW-1]}}, mul_d[k]};
  end

  // Round half up, arithmetic shift, then clip: the value fits only when
  // every bit from the output sign bit upward is identical.
  always_comb begin
    rnd_sum = {node_q[1][ACC_W-1], node_q[1]} + RND;
    scaled  = rnd_sum >>> SHIFT;
    clip_d  = (|scaled[OW-1:DATA_WIDTH-1]) & ~(&scaled[OW-1:DATA_WIDTH-1]);
    if (clip_d) begin
      dout_d = scaled[OW-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                            : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end else begin
      dout_d = scaled[DATA_WIDTH-1:0];
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      for (int i = 1; i < 2*LEAVES; i++) node_q[i] <= '0;
      vld_q  <= '0;
      dout_q <= '0;
      vout_q <= 1'b0;
      sat_q  <= 1'b0;
    end else begin
      for (int k = 0; k < LEAVES; k++) node_q[LEAVES+k] <= prod_d[k];
      for (int i = 1; i < LEAVES; i++) node_q[i] <= node_q[2*i] + node_q[2*i+1];
      // vld_q[0] tracks the tap stage, vld_q[LVL+1] the tree root
      vld_q  <= {vld_q[LVL:0], bus.VIN};
      vout_q <= vld_q[LVL+1];
      sat_q  <= vld_q[LVL+1] & clip_d;
      if (vld_q[LVL+1]) dout_q <= dout_d;
    end
  end

  assign bus.DOUT = dout_q;
  assign bus.VOUT = vout_q;
  assign bus.SAT  = sat_q;
endmodule

// File: tb/tb_fir_param.sv
// tb_fir_param: directed bench for fir_param with default parameters.
// Each driven sample carries a hand-computed expected DOUT/SAT and is due
// five edges after capture; a monitor checks VOUT timing, data, SAT and
// DOUT hold between outputs.
module tb_fir_param;
  logic clk;
  logic rst_n;

  typedef struct {
    int                  due;
    logic signed [12:0]  d;
    bit                  s;
    bit                  cd;
  } exp_t;

  exp_t               exp_q[$];
  exp_t               e;
  int                 edge_cnt = 0;
  int                 n_cmp    = 0;
  int                 n_bad    = 0;
  logic signed [12:0] last_d   = '0;
  bit                 last_known = 1'b1;

  fir_param_if #(.DATA_WIDTH(13), .COEF_WIDTH(13), .TAPS(8)) bus ();

  fir_param #(.DATA_WIDTH(13), .COEF_WIDTH(13), .TAPS(8), .SHIFT(12)) dut (
    .CLK   (clk),
    .RST_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Monitor: 2 time units after each edge.
  always @(posedge clk) begin
    #2;
    edge_cnt++;
    if (exp_q.size() > 0 && exp_q[0].due == edge_cnt) begin
      e = exp_q.pop_front();
      chk("vout", 64'(bus.VOUT), 64'sd1);
      if (e.cd) begin
        chk("dout", 64'(bus.DOUT), 64'(e.d));
        chk("sat", 64'(bus.SAT), 64'(e.s));
        last_d     = e.d;
        last_known = 1'b1;
      end else begin
        last_known = 1'b0;
      end
    end else begin
      chk("vout_idle", 64'(bus.VOUT), 64'sd0);
      chk("sat_idle", 64'(bus.SAT), 64'sd0);
      if (last_known) chk("dout_hold", 64'(bus.DOUT), 64'(last_d));
    end
  end

  // Inputs change 1 unit after an edge; the capture edge is edge_cnt+1.
  task automatic tick(input bit cd, input logic signed [12:0] ed, input bit es);
    @(posedge clk);
    #1;
    if (bus.VIN) exp_q.push_back('{edge_cnt + 6, ed, es, cd});
    bus.VIN     = 1'b0;
    bus.CLOAD   = 1'b0;
    bus.CCOMMIT = 1'b0;
  endtask

  task automatic smp(input logic signed [12:0] din, input bit cd,
                     input logic signed [12:0] ed, input bit es);
    bus.VIN = 1'b1;
    bus.DIN = din;
    tick(cd, ed, es);
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, '0, 1'b0);
  endtask

  task automatic load(input logic [2:0] a, input logic signed [12:0] c);
    bus.CLOAD = 1'b1;
    bus.CADDR = a;
    bus.CDATA = c;
    tick(1'b0, '0, 1'b0);
  endtask

  task automatic commit();
    bus.CCOMMIT = 1'b1;
    tick(1'b0, '0, 1'b0);
  endtask

  task automatic load_ramp();
    for (int k = 0; k < 8; k++) load(3'(k), 13'(k + 1));
    commit();
  endtask

  initial begin
    logic [7:0] gap_pat;
    rst_n       = 1'b0;
    bus.VIN     = 1'b0;
    bus.DIN     = '0;
    bus.CLOAD   = 1'b0;
    bus.CADDR   = '0;
    bus.CDATA   = '0;
    bus.CCOMMIT = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dout", 64'(bus.DOUT), 64'sd0);
    chk("rst_vout", 64'(bus.VOUT), 64'sd0);
    chk("rst_sat", 64'(bus.SAT), 64'sd0);
    rst_n = 1'b1;
    idle(2);

    // Impulse: H[k]=k+1, DIN=4095 -> (4095*(n+1)+2048)>>12 = n+1
    load_ramp();
    smp(13'sd4095, 1'b1, 13'sd1, 1'b0);
    for (int n = 1; n < 8; n++) smp(13'sd0, 1'b1, 13'(n + 1), 1'b0);
    smp(13'sd0, 1'b1, 13'sd0, 1'b0);
    smp(13'sd0, 1'b1, 13'sd0, 1'b0);
    idle(3);

    // Saturation: all H=4095
    for (int k = 0; k < 8; k++) load(3'(k), 13'sd4095);
    commit();
    smp(13'sd4095, 1'b1, 13'sd4094, 1'b0);
    for (int n = 1; n < 10; n++) smp(13'sd4095, 1'b1, 13'sd4095, 1'b1);
    smp(-13'sd4096, 1'b1, 13'sd4095, 1'b1);
    smp(-13'sd4096, 1'b0, '0, 1'b0);
    smp(-13'sd4096, 1'b0, '0, 1'b0);
    smp(-13'sd4096, 1'b1, -13'sd4, 1'b0);
    for (int m = 4; m < 7; m++) smp(-13'sd4096, 1'b0, '0, 1'b0);
    for (int m = 7; m < 10; m++) smp(-13'sd4096, 1'b1, -13'sd4096, 1'b1);
    idle(2);

    // Rounding: H0=2048, others 0 -> y = 2048*DIN
    load(3'd0, 13'sd2048);
    for (int k = 1; k < 8; k++) load(3'(k), 13'sd0);
    commit();
    smp(13'sd1,  1'b1, 13'sd1,  1'b0);
    smp(-13'sd1, 1'b1, 13'sd0,  1'b0);
    smp(13'sd3,  1'b1, 13'sd2,  1'b0);
    smp(-13'sd3, 1'b1, -13'sd1, 1'b0);
    smp(13'sd2,  1'b1, 13'sd1,  1'b0);
    idle(2);

    // Commit boundary: H0 1 -> 2 at sample 4 (with a CLOAD of 3 on the
    // same edge that must stay in shadow), then 2 -> 3 at sample 8
    load(3'd0, 13'sd1);
    commit();
    smp(13'sd4095, 1'b1, 13'sd1, 1'b0);
    smp(13'sd4095, 1'b1, 13'sd1, 1'b0);
    bus.CLOAD = 1'b1; bus.CADDR = 3'd0; bus.CDATA = 13'sd2;
    smp(13'sd4095, 1'b1, 13'sd1, 1'b0);
    smp(13'sd4095, 1'b1, 13'sd1, 1'b0);
    bus.CCOMMIT = 1'b1;
    bus.CLOAD = 1'b1; bus.CADDR = 3'd0; bus.CDATA = 13'sd3;
    smp(13'sd4095, 1'b1, 13'sd2, 1'b0);
    for (int n = 5; n < 8; n++) smp(13'sd4095, 1'b1, 13'sd2, 1'b0);
    bus.CCOMMIT = 1'b1;
    smp(13'sd4095, 1'b1, 13'sd3, 1'b0);
    smp(13'sd4095, 1'b1, 13'sd3, 1'b0);
    idle(2);

    // Gapped VIN 1,0,0,1,1,0,1 carrying an impulse; junk DIN in gaps
    load_ramp();
    for (int n = 0; n < 8; n++) smp(13'sd0, 1'b0, '0, 1'b0);
    gap_pat = 8'b0101_1001;
    begin
      int nv = 0;
      for (int i = 0; i < 7; i++) begin
        if (gap_pat[i]) begin
          smp((nv == 0) ? 13'sd4095 : 13'sd0, 1'b1, 13'(nv + 1), 1'b0);
          nv++;
        end else begin
          bus.DIN = -13'sd1234;
          tick(1'b0, '0, 1'b0);
        end
      end
      for (int n = 4; n < 8; n++) smp(13'sd0, 1'b1, 13'(n + 1), 1'b0);
    end
    smp(13'sd0, 1'b1, 13'sd0, 1'b0);
    idle(3);

    // Reset mid-stream: outputs 1,2,3 emerge, three samples still in flight
    smp(13'sd4095, 1'b1, 13'sd1, 1'b0);
    smp(13'sd0, 1'b1, 13'sd2, 1'b0);
    smp(13'sd0, 1'b1, 13'sd3, 1'b0);
    smp(13'sd0, 1'b0, '0, 1'b0);
    smp(13'sd0, 1'b0, '0, 1'b0);
    smp(13'sd0, 1'b0, '0, 1'b0);
    idle(2);
    #2;
    chk("pre_rst_vout", 64'(bus.VOUT), 64'sd1);
    chk("pre_rst_dout", 64'(bus.DOUT), 64'sd3);
    rst_n = 1'b0;
    exp_q.delete();
    last_d     = '0;
    last_known = 1'b1;
    #1;
    chk("rst_mid_vout", 64'(bus.VOUT), 64'sd0);
    chk("rst_mid_dout", 64'(bus.DOUT), 64'sd0);
    chk("rst_mid_sat", 64'(bus.SAT), 64'sd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(10);
    // Banks cleared: commit of the reset shadow leaves H=0
    commit();
    smp(13'sd4095, 1'b1, 13'sd0, 1'b0);
    // Delay line cleared: only the post-reset sample contributes
    load_ramp();
    smp(13'sd0, 1'b1, 13'sd2, 1'b0);
    smp(13'sd0, 1'b1, 13'sd3, 1'b0);
    idle(8);
    chk("drain", 64'(exp_q.size()), 64'sd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
